// File: rtl/led_matrix_scan_ctrl.sv
// 8x8 LED matrix scan controller: double-buffered frame store, serial column shift,
// latch pulse and per-row dwell, with the buffer swap deferred to the frame boundary.
module led_matrix_scan_ctrl #(
   parameter int unsigned DWELL = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       swap_req,
   output logic       swap_ack,
   output logic       ser_data,
   output logic       ser_clk,
   output logic       latch,
   output logic [7:0] row_sel,
   output logic       frame_start
);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned ROW_W = 3;
   localparam int unsigned ROWS  = 8;
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(15);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic [7:0]       buf_a [ROWS];
   logic [7:0]       buf_b [ROWS];
   logic             front_sel;   // 0: buf_a is front, 1: buf_b is front
   logic             pending;
   logic             swap_now;
   logic [7:0]       front_row_nxt;
   logic             swap_ack_nxt, ser_data_nxt, ser_clk_nxt, latch_nxt, frame_start_nxt;
   logic [7:0]       row_sel_nxt;

   // Next state, swap decision and next registered outputs.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      row_nxt         = row;
      swap_now        = 1'b0;
      front_row_nxt   = '0;
      swap_ack_nxt    = 1'b0;
      ser_data_nxt    = 1'b0;
      ser_clk_nxt     = 1'b0;
      latch_nxt       = 1'b0;
      frame_start_nxt = 1'b0;
      row_sel_nxt     = '0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            row_nxt = '0;
            if (ena) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cnt == SHIFT_LAST) begin
               state_nxt = LATCH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         LATCH: begin
            state_nxt = DISPLAY;
            cnt_nxt   = '0;
         end
         DISPLAY: begin
            if (cnt == DWELL_LAST) begin
               cnt_nxt = '0;
               if (ena) begin
                  state_nxt = SHIFT;
                  row_nxt   = row + ROW_W'(1);
               end else begin
                  state_nxt = IDLE;
                  row_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      swap_now = (pending | swap_req) &
                 (((state == DISPLAY) && (cnt == DWELL_LAST) && (row == ROW_LAST)) ||
                  ((state == IDLE) && ena));

      // Front row as seen next cycle; a same-cycle write into the outgoing back buffer is visible.
      if (swap_now) begin
         front_row_nxt = front_sel ? buf_a[row_nxt] : buf_b[row_nxt];
         if (wr_en && (wr_row == row_nxt)) front_row_nxt = wr_data;
      end else begin
         front_row_nxt = front_sel ? buf_b[row_nxt] : buf_a[row_nxt];
      end

      swap_ack_nxt = swap_now;
      case (state_nxt)
         SHIFT: begin
            ser_data_nxt    = front_row_nxt[~cnt_nxt[3:1]];
            ser_clk_nxt     = cnt_nxt[0];
            frame_start_nxt = (cnt_nxt == '0) && (row_nxt == '0);
         end
         LATCH:   latch_nxt   = 1'b1;
         DISPLAY: row_sel_nxt = 8'b1 << row_nxt;
         default: ;
      endcase
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         row         <= '0;
         pending     <= 1'b0;
         front_sel   <= 1'b0;
         swap_ack    <= 1'b0;
         ser_data    <= 1'b0;
         ser_clk     <= 1'b0;
         latch       <= 1'b0;
         row_sel     <= '0;
         frame_start <= 1'b0;
         for (int unsigned i = 0; i < ROWS; i++) begin
            buf_a[i] <= '0;
            buf_b[i] <= '0;
         end
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         row         <= row_nxt;
         pending     <= (pending | swap_req) & ~swap_now;
         front_sel   <= front_sel ^ swap_now;
         swap_ack    <= swap_ack_nxt;
         ser_data    <= ser_data_nxt;
         ser_clk     <= ser_clk_nxt;
         latch       <= latch_nxt;
         row_sel     <= row_sel_nxt;
         frame_start <= frame_start_nxt;
         if (wr_en) begin
            if (front_sel) buf_a[wr_row] <= wr_data;
            else           buf_b[wr_row] <= wr_data;
         end
      end
   end
endmodule
